// File: rtl/bram_rd_ctrl_pkg.sv
// Shared constants for the BRAM read controller and the BRAM slice it fronts.
// The defaults here must agree with the BRAM slice instance parameters.
package bram_rd_ctrl_pkg;

    localparam int DEF_DATA_WIDTH = 64;
    localparam int DEF_RA_WIDTH   = 12;
    localparam int DEF_RD_LATENCY = 4;
    localparam int DEF_FIFO_DEPTH = 8;

    // The credit counter must be able to hold the value FIFO_DEPTH itself.
    function automatic int credit_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/bram_rd_ctrl_if.sv
// Request / BRAM / response bus of the BRAM read controller.
// master: the controller side; slave: requester, BRAM slice and consumer side.
interface bram_rd_ctrl_if
    import bram_rd_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int RA_WIDTH   = DEF_RA_WIDTH
);
    logic                  i_req_valid;
    logic                  o_req_ready;
    logic [RA_WIDTH-1:0]   i_req_addr;
    logic                  o_re;
    logic [RA_WIDTH-1:0]   o_ra;
    logic [DATA_WIDTH-1:0] i_rd;
    logic                  o_rsp_valid;
    logic                  i_rsp_ready;
    logic [DATA_WIDTH-1:0] o_rsp_data;
    logic                  o_busy;

    modport master (
        input  i_req_valid, i_req_addr, i_rd, i_rsp_ready,
        output o_req_ready, o_re, o_ra, o_rsp_valid, o_rsp_data, o_busy
    );

    modport slave (
        output i_req_valid, i_req_addr, i_rd, i_rsp_ready,
        input  o_req_ready, o_re, o_ra, o_rsp_valid, o_rsp_data, o_busy
    );

endinterface

// File: rtl/bram_rd_ctrl_rsp_fifo.sv
// Response FIFO: power-of-two depth, wrapping pointers, same-cycle push/pop
// allowed at any occupancy, head read straight from storage (no bypass).
module rsp_fifo
    import bram_rd_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic             clk1x,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;

    // Storage write; contents are never observed while empty, so no reset.
    always_ff @(posedge clk1x) begin
        if (push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointers advance independently and wrap naturally modulo DEPTH.
    always_ff @(posedge clk1x or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
        end
    end

    // Occupancy: a simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk1x or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_ONE;
                2'b01:   count_reg <= count_reg - CNT_ONE;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign empty = (count_reg == '0);
    assign full  = (count_reg == CNT_FULL);
    assign head  = mem[rd_ptr_reg];

endmodule

// File: rtl/bram_rd_ctrl.sv
// BRAM read controller: credit-gated request acceptance, registered BRAM
// read strobe, fixed-latency in-flight tracking and an in-order response FIFO.
// A credit is consumed per accepted request and returned per popped response,
// so every returned datum always has a free FIFO slot.
module bram_rd_ctrl
    import bram_rd_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int RA_WIDTH   = DEF_RA_WIDTH,
    parameter int RD_LATENCY = DEF_RD_LATENCY,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic          clk1x,
    input  logic          reset,
    bram_rd_ctrl_if.master bus
);
    localparam int CW = credit_width(FIFO_DEPTH);
    localparam logic [CW-1:0] CREDIT_MAX = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] CREDIT_ONE = CW'(1);

    logic [CW-1:0]       credits_reg;
    logic                re_reg;
    logic [RA_WIDTH-1:0] ra_reg;
    logic                vld_sr_reg [RD_LATENCY];
    logic                stage_in   [RD_LATENCY];

    logic req_ready;
    logic accept;
    logic pop;
    logic push;
    logic fifo_full;
    logic fifo_empty;

    assign req_ready = (credits_reg != '0);
    assign accept    = bus.i_req_valid && req_ready;
    assign pop       = !fifo_empty && bus.i_rsp_ready;
    assign push      = vld_sr_reg[RD_LATENCY-1];

    // Credit bookkeeping; accept and pop in the same cycle cancel out.
    always_ff @(posedge clk1x or negedge reset) begin
        if (!reset) begin
            credits_reg <= CREDIT_MAX;
        end else begin
            case ({accept, pop})
                2'b10:   credits_reg <= credits_reg - CREDIT_ONE;
                2'b01:   credits_reg <= credits_reg + CREDIT_ONE;
                default: credits_reg <= credits_reg;
            endcase
        end
    end

    // Request register: one-cycle read strobe and held address toward the BRAM.
    always_ff @(posedge clk1x or negedge reset) begin
        if (!reset) begin
            re_reg <= 1'b0;
            ra_reg <= '0;
        end else begin
            re_reg <= accept;
            if (accept) begin
                ra_reg <= bus.i_req_addr;
            end
        end
    end

    // Latency shift register: the last stage is high exactly when i_rd carries
    // the datum for a strobe issued RD_LATENCY cycles earlier.
    for (genvar gi = 0; gi < RD_LATENCY; gi++) begin : g_lat
        if (gi == 0) begin : g_head
            assign stage_in[gi] = re_reg;
        end else begin : g_tail
            assign stage_in[gi] = vld_sr_reg[gi-1];
        end

        // Clearing the stages on reset drops reads that were in flight.
        always_ff @(posedge clk1x or negedge reset) begin
            if (!reset) begin
                vld_sr_reg[gi] <= 1'b0;
            end else begin
                vld_sr_reg[gi] <= stage_in[gi];
            end
        end
    end

    rsp_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk1x     (clk1x),
        .reset     (reset),
        .push      (push),
        .push_data (bus.i_rd),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (bus.o_rsp_data)
    );

    // The credit scheme guarantees a full FIFO is never pushed without a pop.
    a_no_overflow: assert property (@(posedge clk1x) disable iff (!reset)
        !(push && fifo_full && !pop));

    assign bus.o_req_ready = req_ready;
    assign bus.o_re        = re_reg;
    assign bus.o_ra        = ra_reg;
    assign bus.o_rsp_valid = !fifo_empty;
    assign bus.o_busy      = (credits_reg != CREDIT_MAX);

endmodule

// File: tb/tb_bram_rd_ctrl.sv
// Bench for bram_rd_ctrl: fixed-latency BRAM model, queue-based reference
// model checked every cycle, plus directed scenarios with literal expectations.
module tb_bram_rd_ctrl;
    import bram_rd_ctrl_pkg::*;

    localparam int DW    = 64;
    localparam int AW    = 12;
    localparam int LAT   = 4;
    localparam int DEPTH = 8;

    logic clk1x = 1'b0;
    logic reset = 1'b1;

    always #5 clk1x = ~clk1x;

    bram_rd_ctrl_if #(.DATA_WIDTH(DW), .RA_WIDTH(AW)) bus ();

    bram_rd_ctrl #(
        .DATA_WIDTH (DW),
        .RA_WIDTH   (AW),
        .RD_LATENCY (LAT),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk1x (clk1x),
        .reset (reset),
        .bus   (bus.master)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // BRAM contents and its fixed-latency read pipe (not reset-aware, like real BRAM)
    logic [DW-1:0] bram_mem [1 << AW];
    logic          pipe_v   [LAT];
    logic [AW-1:0] pipe_a   [LAT];

    // Reference model: accepted reads become visible LAT+2 cycles later, in order
    typedef struct {
        int            vis;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } ent_t;

    ent_t          inflight_q [$];
    ent_t          fifo_q     [$];
    int            credits_m  = DEPTH;
    logic          prev_acc   = 1'b0;
    logic [AW-1:0] prev_addr  = '0;
    int            pop_cnt    = 0;

    // Drive i_rd for strobes issued LAT cycles ago; junk otherwise
    always @(posedge clk1x) begin
        #1;
        if (pipe_v[LAT-1]) bus.i_rd = bram_mem[pipe_a[LAT-1]];
        else               bus.i_rd = {$urandom(), $urandom()};
    end

    // Per-cycle monitor: record BRAM strobe, compare DUT to model, advance model
    always @(negedge clk1x) begin
        logic exp_valid;
        logic acc;
        logic pop;
        ent_t e;
        for (int k = LAT - 1; k > 0; k--) begin
            pipe_v[k] = pipe_v[k-1];
            pipe_a[k] = pipe_a[k-1];
        end
        pipe_v[0] = bus.o_re;
        pipe_a[0] = bus.o_ra;

        if (!reset) begin
            inflight_q.delete();
            fifo_q.delete();
            credits_m = DEPTH;
            prev_acc  = 1'b0;
            chk("rst_o_re",      bus.o_re,        1'b0);
            chk("rst_o_ra",      bus.o_ra,        '0);
            chk("rst_rsp_valid", bus.o_rsp_valid, 1'b0);
            chk("rst_busy",      bus.o_busy,      1'b0);
            chk("rst_req_ready", bus.o_req_ready, 1'b1);
        end else begin
            while (inflight_q.size() > 0 && inflight_q[0].vis <= cyc) begin
                fifo_q.push_back(inflight_q.pop_front());
            end
            exp_valid = (fifo_q.size() > 0);
            chk("req_ready", bus.o_req_ready, credits_m > 0);
            chk("o_re",      bus.o_re,        prev_acc);
            if (prev_acc) chk("o_ra", bus.o_ra, prev_addr);
            chk("rsp_valid", bus.o_rsp_valid, exp_valid);
            if (exp_valid) chk("rsp_data", bus.o_rsp_data, fifo_q[0].data);
            chk("busy",      bus.o_busy,      credits_m != DEPTH);
            chk("credits",   64'(dut.credits_reg), 64'(credits_m));
            chk("occupancy", 64'(dut.u_fifo.count_reg), 64'(fifo_q.size()));
            chk("conserve",  64'(int'(dut.credits_reg) + inflight_q.size() + int'(dut.u_fifo.count_reg)), 64'(DEPTH));

            acc = bus.i_req_valid && (credits_m > 0);
            pop = exp_valid && bus.i_rsp_ready;
            if (pop) begin
                $display("rsp %0d: addr=%h data=%h cycle=%0d", pop_cnt, fifo_q[0].addr, fifo_q[0].data, cyc);
                pop_cnt++;
                void'(fifo_q.pop_front());
                credits_m++;
            end
            if (acc) begin
                e.vis  = cyc + LAT + 2;
                e.addr = bus.i_req_addr;
                e.data = bram_mem[bus.i_req_addr];
                inflight_q.push_back(e);
                credits_m--;
            end
            prev_acc  = acc;
            prev_addr = bus.i_req_addr;
        end
        cyc++;
    end

    task automatic next();
        @(posedge clk1x);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) next();
    endtask

    initial begin
        int n, first, last, acc_n, pv, pr;
        for (int i = 0; i < (1 << AW); i++) bram_mem[i] = {$urandom(), $urandom()};
        for (int k = 0; k < LAT; k++) begin
            pipe_v[k] = 1'b0;
            pipe_a[k] = '0;
        end
        bus.i_req_valid = 1'b0;
        bus.i_req_addr  = '0;
        bus.i_rsp_ready = 1'b0;
        bus.i_rd        = '0;
        #2 reset = 1'b0;
        repeat (3) @(posedge clk1x);
        #1 reset = 1'b1;
        idle(2);

        // Single read: accept at cycle 0, strobe at 1, response visible at 6
        bus.i_req_valid = 1'b1;
        bus.i_req_addr  = 12'h012;
        bus.i_rsp_ready = 1'b1;
        @(negedge clk1x);
        chk("t1_accept", bus.o_req_ready, 1'b1);
        next();
        bus.i_req_valid = 1'b0;
        @(negedge clk1x);
        chk("t1_re", bus.o_re, 1'b1);
        chk("t1_ra", bus.o_ra, 12'h012);
        next();
        for (int c = 2; c <= 5; c++) begin
            @(negedge clk1x);
            chk("t1_no_early", bus.o_rsp_valid, 1'b0);
            next();
        end
        @(negedge clk1x);
        chk("t1_valid_c6", bus.o_rsp_valid, 1'b1);
        chk("t1_data", bus.o_rsp_data, bram_mem[12'h012]);
        next();
        @(negedge clk1x);
        chk("t1_busy_after", bus.o_busy, 1'b0);
        next();

        // Streaming: 100 back-to-back requests with the consumer always ready
        n = 0; first = -1; last = -1;
        bus.i_rsp_ready = 1'b1;
        for (int i = 0; i < 120; i++) begin
            bus.i_req_valid = (i < 100);
            bus.i_req_addr  = AW'(i + 256);
            @(negedge clk1x);
            if (i < 100) chk("t2_ready", bus.o_req_ready, 1'b1);
            if (bus.o_rsp_valid && bus.i_rsp_ready) begin
                if (first < 0) first = i;
                last = i;
                n++;
            end
            next();
        end
        chk("t2_count", 64'(n), 64'd100);
        chk("t2_first", 64'(first), 64'd6);
        chk("t2_span",  64'(last - first), 64'd99);

        // Backpressure: 8 accepts fill all credits, one pop frees exactly one
        acc_n = 0;
        bus.i_rsp_ready = 1'b0;
        bus.i_req_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.i_req_addr = AW'($urandom());
            @(negedge clk1x);
            if (bus.o_req_ready) acc_n++;
            next();
        end
        chk("t3_accepts", 64'(acc_n), 64'd8);
        chk("t3_stalled", bus.o_req_ready, 1'b0);
        acc_n = 0;
        bus.i_rsp_ready = 1'b1;
        @(negedge clk1x);
        if (bus.o_req_ready) acc_n++;
        next();
        bus.i_rsp_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk1x);
            if (bus.o_req_ready) acc_n++;
            next();
        end
        chk("t3_one_more", 64'(acc_n), 64'd1);
        bus.i_req_valid = 1'b0;
        bus.i_rsp_ready = 1'b1;
        idle(20);
        @(negedge clk1x);
        chk("t3_drained", bus.o_busy, 1'b0);
        next();

        // Full FIFO then simultaneous push/pop streaming across pointer wrap
        bus.i_rsp_ready = 1'b0;
        bus.i_req_valid = 1'b1;
        for (int i = 0; i < 45; i++) begin
            if (i == 15) bus.i_rsp_ready = 1'b1;
            bus.i_req_addr = AW'(i * 37);
            next();
        end
        bus.i_req_valid = 1'b0;
        idle(20);

        // Reset with 3 reads in flight and 2 buffered; stale data must vanish
        bus.i_rsp_ready = 1'b0;
        bus.i_req_valid = 1'b1;
        idle(2);
        bus.i_req_valid = 1'b0;
        idle(8);
        bus.i_req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.i_req_addr = AW'(i + 3000);
            next();
        end
        bus.i_req_valid = 1'b0;
        next();
        @(negedge clk1x);
        chk("t5_pre_rst_busy", bus.o_busy, 1'b1);
        chk("t5_pre_rst_buf",  64'(dut.u_fifo.count_reg), 64'd2);
        next();
        reset = 1'b0;
        next();
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk1x);
            chk("t5_no_stale", bus.o_rsp_valid, 1'b0);
            chk("t5_credits",  64'(dut.credits_reg), 64'd8);
            next();
        end
        bus.i_rsp_ready = 1'b1;
        idle(2);

        // Random traffic with phase-varying valid/ready bias
        pv = 50; pr = 50;
        for (int i = 0; i < 10000; i++) begin
            if (i % 500 == 0) begin
                pv = $urandom_range(5, 100);
                pr = $urandom_range(5, 100);
            end
            bus.i_req_valid = ($urandom_range(0, 99) < pv);
            bus.i_req_addr  = AW'($urandom());
            bus.i_rsp_ready = ($urandom_range(0, 99) < pr);
            next();
        end
        bus.i_req_valid = 1'b0;
        bus.i_rsp_ready = 1'b1;
        idle(30);
        @(negedge clk1x);
        chk("t6_drained", bus.o_busy, 1'b0);
        next();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
